// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues one instruction-memory read per cycle against a
// single-cycle-latency memory and buffers {instruction, PC} pairs in a 2-entry FIFO.
module instr_fetch #(
   parameter int DATA_WIDTH  = 32,
   parameter int INSTR_WIDTH = 32,
   parameter int DEPTH       = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [DATA_WIDTH-1:0]  PC,
   input  logic                   redirect,
   output logic                   pc_en,
   output logic                   mem_req,
   output logic [DATA_WIDTH-1:0]  mem_addr,
   input  logic [INSTR_WIDTH-1:0] mem_rdata,
   output logic [INSTR_WIDTH-1:0] instr,
   output logic [DATA_WIDTH-1:0]  instr_pc,
   output logic                   instr_valid,
   input  logic                   instr_ready
);

   logic                   pending;
   logic [DATA_WIDTH-1:0]  req_pc;
   logic [1:0]             count;
   logic                   head;
   logic                   tail;
   logic [INSTR_WIDTH-1:0] instr_q [DEPTH];
   logic [DATA_WIDTH-1:0]  pc_q    [DEPTH];

   logic                   pop;
   logic                   push;
   logic                   credit;
   logic [2:0]             occupancy;

   // A new request is allowed only if the slot it will need is guaranteed free
   // when its data lands, counting the in-flight response and this cycle's pop.
   always_comb begin
      instr_valid = (count != 2'd0) & ~redirect;
      pop         = instr_valid & instr_ready;
      push        = pending & ~redirect;
      occupancy   = {1'b0, count} + {2'b00, pending} - {2'b00, pop};
      credit      = occupancy < 3'(DEPTH);
      mem_req     = credit & ~redirect & rst;
      pc_en       = mem_req;
      mem_addr    = PC;
      instr       = instr_q[head];
      instr_pc    = pc_q[head];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pending <= 1'b0;
         req_pc  <= '0;
      end else begin
         pending <= mem_req;
         if (mem_req) begin
            req_pc <= PC;
         end
      end
   end

   // Redirect discards both the buffered entries and the response in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= 2'd0;
         head  <= 1'b0;
         tail  <= 1'b0;
      end else if (redirect) begin
         count <= 2'd0;
         head  <= 1'b0;
         tail  <= 1'b0;
      end else begin
         if (push) begin
            tail <= tail + 1'b1;
         end
         if (pop) begin
            head <= head + 1'b1;
         end
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            instr_q[i] <= '0;
            pc_q[i]    <= '0;
         end
      end else if (push) begin
         instr_q[tail] <= mem_rdata;
         pc_q[tail]    <= req_pc;
      end
   end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit on the consumer side of the program counter. It takes the current PC and issues one instruction-memory read per cycle. It tracks the single-cycle memory latency and buffers returned instructions, paired with their PC, in a 2-entry FIFO for decode. It advances the PC only when a fetch is accepted, flushes on a control-flow redirect, and throttles the PC under decode backpressure.

## Interface
- DATA_WIDTH, 32, PC / memory address width
- INSTR_WIDTH, 32, instruction word width
- DEPTH, 2, FIFO entries; fixed at 2 for this revision
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- PC  in  DATA_WIDTH  current PC from the PC register
- redirect  in  1  branch/jump taken this cycle; squashes all younger fetches
- pc_en  out  1  PC register may advance to its next value at this edge
- mem_req  out  1  instruction memory read strobe
- mem_addr  out  DATA_WIDTH  read address; equals PC
- mem_rdata  in  INSTR_WIDTH  read data, valid exactly 1 cycle after mem_req
- instr  out  INSTR_WIDTH  FIFO head instruction
- instr_pc  out  DATA_WIDTH  PC of FIFO head
- instr_valid  out  1  FIFO non-empty and not redirecting
- instr_ready  in  1  decode accepts head

## Operation
- State: `pending` (1 bit, plus captured request PC), FIFO `count` (0..2), head/tail pointers (1 bit each, wrap mod 2).
- pop = instr_valid & instr_ready.
- credit = (count + pending − pop) < DEPTH.
- mem_req = pc_en = credit & ~redirect & rst. mem_addr = PC combinationally.
- On an edge with mem_req=1: pending←1 and req_pc←PC. Otherwise pending←0.
- On an edge with pending=1 and no redirect: push {mem_rdata, req_pc} at tail, tail←tail+1.
- Pop advances head. count updates by push − pop; simultaneous push+pop leaves count unchanged.
- Redirect, cycle-level:
  - instr_valid is forced 0, so no pop.
  - mem_req=0 and pc_en=0.
  - At the edge: count←0, pointers←0, pending←0. The in-flight response is discarded.
  - The PC register loads its target through its own path. Fetch resumes the next cycle at the new PC.
- Overflow and underflow cannot occur by construction. The bench asserts that count never exceeds 2 and that no pop happens while count=0.
- Arithmetic: PC is passed through unchanged. Increment is the PC register's job; this block only gates it with pc_en.

## Timing
- Reset (rst low, asynchronous):
  - count=0, pending=0, pointers=0.
  - instr_valid=0, instr=0, instr_pc=0, mem_req=0, pc_en=0.
- First cycle after rst rises: mem_req=1, pc_en=1.
- Latency: request in cycle t → data captured at end of t+1 → instr_valid in t+2. No bypass.
- Throughput: 1 instruction/cycle sustained with instr_ready held high (steady state count=1, pending=1).
- Backpressure: with instr_ready low, the FIFO fills (count=2) and mem_req/pc_en drop. They re-assert in the same cycle instr_ready rises with count=2, pending=0 (credit counts the pop).
- instr/instr_pc hold stable while instr_valid=1 and instr_ready=0.
- Reset mid-operation: everything clears immediately. Any pending response is lost. No spurious instr_valid after release.

## Test plan
- Reset: hold rst=0 with random inputs → instr_valid=0, mem_req=0, pc_en=0, instr=0. Release → mem_req=1, mem_addr=PC=0x0 in the first cycle.
- Stream: PC 0x0,0x4,0x8,… with memory returning addr^0xA5A5_0000 and instr_ready=1 → instr_valid from cycle 2; instr_pc 0x0,0x4,0x8 on consecutive cycles with matching data; pc_en=1 every cycle.
- Backpressure: instr_ready=0 from cycle 0 → exactly 2 requests (0x0, 0x4), then mem_req=0. Head holds 0x0. Raise ready → 0x0, 0x4, 0x8 delivered in order with no gap after the first pop; no duplicate and no skipped PC.
- Redirect: pulse redirect while count=1 and pending=1 → same cycle instr_valid=0, mem_req=0. Next cycle count=0 and mem_addr=target 0x100. instr_pc=0x100 two cycles later; no stale instruction emitted.
- Full with simultaneous pop+push: count=1, pending=1, instr_ready=1 → count stays 1 and mem_req stays 1 across 10 cycles.
- Mid-stream reset: assert rst=0 asynchronously between edges with count=2 → outputs clear before the next edge. After release, the first instr_pc equals the PC presented, not the old FIFO contents.
